freq_gate_ctrl: RTL and testbench

Gate-time sequencer for the frequency meter. It clears the decimal counter chain, opens a precisely timed gate window on the counter enable, waits for the ripple chain to settle, then issues a latch strobe. It presents each completed measurement to the display/readout logic through a valid/ready handshake. It runs in the reference-clock domain; the counter chain runs on the measured signal.

---
 rtl/freq_meter_pkg.sv | 33 +++
 rtl/sync_edge.sv | 29 ++
 rtl/freq_gate_ctrl.sv | 134 +++++++++++++
 tb/tb_freq_gate_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency meter.
// State encoding, gate-range codes and gate-length math.
package freq_meter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        LATCH
    } state_t;

    localparam logic [1:0] RANGE_10MS  = 2'd0;
    localparam logic [1:0] RANGE_100MS = 2'd1;
    localparam logic [1:0] RANGE_1S    = 2'd2;
    localparam logic [1:0] RANGE_10S   = 2'd3;

    // Gate length in reference-clock cycles for a range code.
    function automatic logic [31:0] gate_cycles(
        input int unsigned clk_freq,
        input logic [1:0]  range
    );
        logic [31:0] w_base;
        w_base = clk_freq / 100;
        unique case (range)
            RANGE_10MS:  gate_cycles = w_base;
            RANGE_100MS: gate_cycles = w_base * 32'd10;
            RANGE_1S:    gate_cycles = w_base * 32'd100;
            RANGE_10S:   gate_cycles = w_base * 32'd1000;
        endcase
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a rising-edge pulse.
// Reusable for any flag crossing into the clk domain.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Shift the async input through two flops, keep one more for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise_o = r_sync & ~r_prev;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-time sequencer: clear, gate, settle, latch, then
// hand the result to the readout over valid/ready.
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned CLR_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       cont_i,
    input  logic [1:0] range_i,
    input  logic       ovf_i,
    output logic       cnt_clr_o,
    output logic       cnt_en_o,
    output logic       latch_o,
    output logic       result_valid_o,
    input  logic       result_ready_i,
    output logic       ovf_o,
    output logic [1:0] range_o,
    output logic       busy_o
);

    localparam logic [31:0] CLR_LAST    = 32'(CLR_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_timer;
    logic [1:0]  r_range;
    logic        r_sticky;

    logic        w_ovf_rise;
    logic        w_start;
    logic        w_done;
    logic        w_in_window;
    logic [31:0] w_gate_last;

    sync_edge u_ovf_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (ovf_i),
        .rise_o (w_ovf_rise)
    );

    assign w_start = (start_i | cont_i)
                   & (~result_valid_o | result_ready_i);

    assign w_done      = (r_timer == 32'd0);
    assign w_in_window = (r_state == GATE) || (r_state == SETTLE);
    assign w_gate_last = gate_cycles(CLK_FREQ, r_range) - 32'd1;

    // Sticky overflow: cleared before each gate, set by edges in the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (r_state == CLEAR) begin
            r_sticky <= 1'b0;
        end else if (w_ovf_rise && w_in_window) begin
            r_sticky <= 1'b1;
        end
    end

    // Measurement sequencer with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_timer        <= 32'd0;
            r_range        <= 2'd0;
            cnt_clr_o      <= 1'b0;
            cnt_en_o       <= 1'b0;
            latch_o        <= 1'b0;
            result_valid_o <= 1'b0;
            ovf_o          <= 1'b0;
            range_o        <= 2'd0;
            busy_o         <= 1'b0;
        end else begin
            latch_o <= 1'b0;
            if (result_valid_o && result_ready_i) begin
                result_valid_o <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state   <= CLEAR;
                        r_timer   <= CLR_LAST;
                        r_range   <= range_i;
                        cnt_clr_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (w_done) begin
                        r_state   <= GATE;
                        r_timer   <= w_gate_last;
                        cnt_clr_o <= 1'b0;
                        cnt_en_o  <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                GATE: begin
                    if (w_done) begin
                        r_state  <= SETTLE;
                        r_timer  <= SETTLE_LAST;
                        cnt_en_o <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                SETTLE: begin
                    if (w_done) begin
                        r_state <= LATCH;
                        latch_o <= 1'b1;
                        ovf_o   <= r_sticky | w_ovf_rise;
                        range_o <= r_range;
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                LATCH: begin
                    r_state        <= IDLE;
                    busy_o         <= 1'b0;
                    result_valid_o <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl.
// Scoreboard of expected results checked at each latch strobe.
module tb_freq_gate_ctrl;

    localparam int CLR = 4;
    localparam int SET = 8;
    localparam int N0  = 10;

    typedef struct {
        int         n;
        logic       ovf;
        logic [1:0] rng;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       cont_i = 1'b0;
    logic [1:0] range_i = 2'd0;
    logic       ovf_i = 1'b0;
    logic       result_ready_i = 1'b0;
    logic       cnt_clr_o;
    logic       cnt_en_o;
    logic       latch_o;
    logic       result_valid_o;
    logic       ovf_o;
    logic [1:0] range_o;
    logic       busy_o;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    freq_gate_ctrl #(
        .CLK_FREQ      (1000),
        .CLR_CYCLES    (CLR),
        .SETTLE_CYCLES (SET)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .cont_i         (cont_i),
        .range_i        (range_i),
        .ovf_i          (ovf_i),
        .cnt_clr_o      (cnt_clr_o),
        .cnt_en_o       (cnt_en_o),
        .latch_o        (latch_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .ovf_o          (ovf_o),
        .range_o        (range_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // Monitor: gate run length and scoreboard pop on latch
    int   en_run = 0;
    logic prev_en = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            en_run  = 0;
            prev_en = 1'b0;
        end else begin
            if (cnt_en_o) en_run = prev_en ? en_run + 1 : 1;
            prev_en = cnt_en_o;
            if (latch_o) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_latch", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("sb_gate_len", en_run, mon_e.n);
                    check_eq("sb_ovf", {31'd0, ovf_o},
                             {31'd0, mon_e.ovf});
                    check_eq("sb_range", {30'd0, range_o},
                             {30'd0, mon_e.rng});
                end
            end
        end
    end

    function automatic logic [31:0] out_vec();
        return {24'd0, cnt_clr_o, cnt_en_o, latch_o,
                result_valid_o, ovf_o, range_o, busy_o};
    endfunction

    // Request one shot; returns at the negedge of cycle 1
    task automatic start_shot(
        input logic [1:0] r,
        input int         n,
        input logic       ovf
    );
        exp_t e;
        e.n   = n;
        e.ovf = ovf;
        e.rng = r;
        @(negedge clk);
        range_i = r;
        start_i = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int c;
        c = 0;
        while (busy_o && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        check_eq("wait_idle_timeout", {31'd0, busy_o}, 0);
    endtask

    initial begin
        exp_t e;
        logic [31:0] m_clr, m_en, m_lat, m_val, m_bsy;
        logic [31:0] x_clr, x_en, x_lat, x_val, x_bsy;
        int bad_lat, bad_val, clr_rise, act;
        logic prev_clr;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", out_vec(), 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_after_reset", out_vec(), 0);

        // 1: single shot, range 0, no ready
        e.n = N0; e.ovf = 1'b0; e.rng = 2'd0;
        @(negedge clk);
        range_i = 2'd0;
        start_i = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        m_clr = 0; m_en = 0; m_lat = 0; m_val = 0; m_bsy = 0;
        x_clr = 0; x_en = 0; x_lat = 0; x_val = 0; x_bsy = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) start_i = 1'b0;
            m_clr[k] = cnt_clr_o;
            m_en[k]  = cnt_en_o;
            m_lat[k] = latch_o;
            m_val[k] = result_valid_o;
            m_bsy[k] = busy_o;
            x_clr[k] = (k >= 1) && (k <= CLR);
            x_en[k]  = (k > CLR) && (k <= CLR + N0);
            x_lat[k] = (k == CLR + N0 + SET + 1);
            x_val[k] = (k > CLR + N0 + SET + 1);
            x_bsy[k] = (k <= CLR + N0 + SET + 1);
        end
        check_eq("t1_clr_cycles", m_clr, x_clr);
        check_eq("t1_en_cycles", m_en, x_en);
        check_eq("t1_latch_cycles", m_lat, x_lat);
        check_eq("t1_valid_cycles", m_val, x_val);
        check_eq("t1_busy_cycles", m_bsy, x_bsy);

        // 2: continuous, ready=1, cont dropped mid third run
        @(negedge clk);
        cont_i = 1'b1;
        result_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) sb_q.push_back(e);
        @(posedge clk);
        bad_lat = 0; bad_val = 0; clr_rise = 0;
        prev_clr = 1'b0;
        for (int k = 1; k <= 96; k++) begin
            @(negedge clk);
            if (latch_o != (k == 23 || k == 47 || k == 71))
                bad_lat++;
            if (result_valid_o != (k == 24 || k == 48 || k == 72))
                bad_val++;
            if (cnt_clr_o && !prev_clr) clr_rise++;
            prev_clr = cnt_clr_o;
            if (k == 50) cont_i = 1'b0;
        end
        check_eq("t2_latch_bad_cycles", bad_lat, 0);
        check_eq("t2_valid_bad_cycles", bad_val, 0);
        check_eq("t2_gate_count", clr_rise, 3);
        check_eq("t2_busy_end", {31'd0, busy_o}, 0);

        // 3: backpressure then release
        @(negedge clk);
        cont_i = 1'b1;
        result_ready_i = 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        repeat (40) @(negedge clk);
        check_eq("t3_valid_held", {31'd0, result_valid_o}, 1);
        check_eq("t3_busy_low", {31'd0, busy_o}, 0);
        check_eq("t3_no_clear", {31'd0, cnt_clr_o}, 0);
        result_ready_i = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        check_eq("t3_valid_drop", {31'd0, result_valid_o}, 0);
        check_eq("t3_clr_rise", {31'd0, cnt_clr_o}, 1);
        cont_i = 1'b0;
        wait_idle(200);

        // 4: overflow pulse inside gate, then a clean run
        start_shot(2'd0, N0, 1'b1);
        repeat (6) @(negedge clk);
        ovf_i = 1'b1;
        repeat (3) @(negedge clk);
        ovf_i = 1'b0;
        repeat (14) @(negedge clk);
        check_eq("t4_valid", {31'd0, result_valid_o}, 1);
        check_eq("t4_ovf_set", {31'd0, ovf_o}, 1);
        wait_idle(200);
        start_shot(2'd0, N0, 1'b0);
        wait_idle(200);
        @(negedge clk);
        check_eq("t4_ovf_clear", {31'd0, ovf_o}, 0);

        // 5: range captured at start only
        start_shot(2'd2, 1000, 1'b0);
        repeat (19) @(negedge clk);
        range_i = 2'd0;
        wait_idle(2000);
        check_eq("t5_range_o", {30'd0, range_o}, 2);

        // 6: async reset mid gate
        start_shot(2'd1, 100, 1'b0);
        repeat (29) @(negedge clk);
        check_eq("t6_gate_open", {31'd0, cnt_en_o}, 1);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check_eq("t6_async_reset", out_vec(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        act = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_vec() != 0) act++;
        end
        check_eq("t6_quiet_after_reset", act, 0);
        start_shot(2'd0, N0, 1'b0);
        wait_idle(200);
        repeat (2) @(negedge clk);
        check_eq("sb_leftover", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
